// File: rtl/fir_xifu_mem_resp_if.sv
// Memory request/result channel between the FIR coprocessor and its core-side responder,
// plus the OBI data port the responder drives.
interface fir_xifu_mem_resp_if #(
    parameter int unsigned ID_WIDTH = 4
);
    logic                mem_valid_i;
    logic                mem_ready_o;
    logic [ID_WIDTH-1:0] mem_id_i;
    logic [31:0]         mem_addr_i;
    logic                mem_we_i;
    logic [2:0]          mem_size_i;
    logic [3:0]          mem_be_i;
    logic [31:0]         mem_wdata_i;
    logic                mem_last_i;
    logic                mem_resp_exc_o;
    logic [5:0]          mem_resp_exccode_o;

    logic                obi_req_o;
    logic                obi_gnt_i;
    logic [31:0]         obi_addr_o;
    logic                obi_we_o;
    logic [3:0]          obi_be_o;
    logic [31:0]         obi_wdata_o;
    logic                obi_rvalid_i;
    logic [31:0]         obi_rdata_i;
    logic                obi_err_i;

    logic                mem_result_valid_o;
    logic [ID_WIDTH-1:0] mem_result_id_o;
    logic [31:0]         mem_result_rdata_o;
    logic                mem_result_err_o;
    logic                busy_o;
    logic                protocol_err_o;

    modport slave (
        input  mem_valid_i, mem_id_i, mem_addr_i, mem_we_i, mem_size_i, mem_be_i,
               mem_wdata_i, mem_last_i, obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
        output mem_ready_o, mem_resp_exc_o, mem_resp_exccode_o, obi_req_o, obi_addr_o,
               obi_we_o, obi_be_o, obi_wdata_o, mem_result_valid_o, mem_result_id_o,
               mem_result_rdata_o, mem_result_err_o, busy_o, protocol_err_o
    );

    modport master (
        output mem_valid_i, mem_id_i, mem_addr_i, mem_we_i, mem_size_i, mem_be_i,
               mem_wdata_i, mem_last_i, obi_gnt_i, obi_rvalid_i, obi_rdata_i, obi_err_i,
        input  mem_ready_o, mem_resp_exc_o, mem_resp_exccode_o, obi_req_o, obi_addr_o,
               obi_we_o, obi_be_o, obi_wdata_o, mem_result_valid_o, mem_result_id_o,
               mem_result_rdata_o, mem_result_err_o, busy_o, protocol_err_o
    );
endinterface

// File: rtl/fir_xifu_mem_resp.sv
// Core-side responder for the FIR coprocessor memory channel: legality check, OBI forwarding,
// in-order result return through an outstanding-ID FIFO.
module fir_xifu_mem_resp #(
    parameter int unsigned ID_WIDTH    = 4,
    parameter int unsigned OUTSTANDING = 2
) (
    input logic                clk_i,
    input logic                rst_i,
    fir_xifu_mem_resp_if.slave bus
);
    localparam int unsigned CW = $clog2(OUTSTANDING + 1);
    localparam int unsigned PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    logic [ID_WIDTH-1:0] id_mem_q [OUTSTANDING];
    logic                we_mem_q [OUTSTANDING];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]       cnt_q, cnt_d;

    logic                res_valid_q;
    logic [ID_WIDTH-1:0] res_id_q;
    logic [31:0]         res_rdata_q;
    logic                res_err_q;
    logic                busy_q;
    logic                perr_q;

    logic       size_ok, aligned, legal, full, empty, req, push, pop;
    logic [5:0] exccode;

    always_comb begin
        size_ok = 1'b0;
        aligned = 1'b0;
        case (bus.mem_size_i)
            3'b001: begin size_ok = 1'b1; aligned = 1'b1; end
            3'b010: begin size_ok = 1'b1; aligned = ~bus.mem_addr_i[0]; end
            3'b100: begin size_ok = 1'b1; aligned = (bus.mem_addr_i[1:0] == 2'b00); end
            default: ;
        endcase
        legal = size_ok & aligned;
        if (!size_ok) exccode = bus.mem_we_i ? 6'd7 : 6'd5;
        else          exccode = bus.mem_we_i ? 6'd6 : 6'd4;
    end

    // Full is taken from the registered count only; a pop frees its slot one cycle later.
    assign full  = (cnt_q == CW'(OUTSTANDING));
    assign empty = (cnt_q == '0);
    assign req   = bus.mem_valid_i & legal & ~full;
    assign push  = req & bus.obi_gnt_i;
    assign pop   = bus.obi_rvalid_i & ~empty;

    assign bus.obi_req_o          = req;
    assign bus.obi_addr_o         = bus.mem_addr_i;
    assign bus.obi_we_o           = bus.mem_we_i;
    assign bus.obi_be_o           = bus.mem_be_i;
    assign bus.obi_wdata_o        = bus.mem_wdata_i;
    assign bus.mem_ready_o        = legal ? push : bus.mem_valid_i;
    assign bus.mem_resp_exc_o     = bus.mem_valid_i & ~legal;
    assign bus.mem_resp_exccode_o = (bus.mem_valid_i & ~legal) ? exccode : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) wr_ptr_d = (wr_ptr_q == PW'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = (rd_ptr_q == PW'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < OUTSTANDING; i++) begin
                id_mem_q[i] <= '0;
                we_mem_q[i] <= 1'b0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= '0;
            res_rdata_q <= '0;
            res_err_q   <= 1'b0;
            busy_q      <= 1'b0;
            perr_q      <= 1'b0;
        end else begin
            if (push) begin
                id_mem_q[wr_ptr_q] <= bus.mem_id_i;
                we_mem_q[wr_ptr_q] <= bus.mem_we_i;
            end
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            busy_q      <= (cnt_d != '0);
            res_valid_q <= pop;
            if (pop) begin
                res_id_q    <= id_mem_q[rd_ptr_q];
                res_rdata_q <= we_mem_q[rd_ptr_q] ? '0 : bus.obi_rdata_i;
                res_err_q   <= bus.obi_err_i;
            end
            if (bus.obi_rvalid_i && empty) perr_q <= 1'b1;
        end
    end

    assign bus.mem_result_valid_o = res_valid_q;
    assign bus.mem_result_id_o    = res_id_q;
    assign bus.mem_result_rdata_o = res_rdata_q;
    assign bus.mem_result_err_o   = res_err_q;
    assign bus.busy_o             = busy_q;
    assign bus.protocol_err_o     = perr_q;
endmodule

// File: tb/tb_fir_xifu_mem_resp.sv
// Directed and random checks of fir_xifu_mem_resp against a queue-based transaction model.
module tb_fir_xifu_mem_resp;
    localparam int unsigned OUT = 2;

    typedef struct {
        logic [3:0] id;
        logic       we;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ent_t        q[$];
    logic        e_rv = 1'b0;
    logic [3:0]  e_id = '0;
    logic [31:0] e_rd = '0;
    logic        e_er = 1'b0;
    logic        e_perr = 1'b0;

    always #5 clk = ~clk;

    fir_xifu_mem_resp_if #(.ID_WIDTH(4)) ifc ();

    fir_xifu_mem_resp #(.ID_WIDTH(4), .OUTSTANDING(OUT)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (ifc)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs after negedge, check combinational outputs,
    // advance the model at posedge, then check registered outputs.
    task automatic cyc(input logic v, input logic [3:0] id, input logic [31:0] addr,
                       input logic we, input logic [2:0] size, input logic [31:0] wd,
                       input logic gnt, input logic rv, input logic [31:0] rd, input logic er);
        logic size_ok, align, legal, e_req, e_rdy, e_exc;
        logic [5:0] code;
        int had;
        ifc.mem_valid_i  = v;
        ifc.mem_id_i     = id;
        ifc.mem_addr_i   = addr;
        ifc.mem_we_i     = we;
        ifc.mem_size_i   = size;
        ifc.mem_be_i     = 4'hF;
        ifc.mem_wdata_i  = wd;
        ifc.mem_last_i   = 1'b1;
        ifc.obi_gnt_i    = gnt;
        ifc.obi_rvalid_i = rv;
        ifc.obi_rdata_i  = rd;
        ifc.obi_err_i    = er;
        #1;
        size_ok = (size == 3'd1) || (size == 3'd2) || (size == 3'd4);
        align   = (size == 3'd4) ? (addr % 4 == 0) : (size == 3'd2) ? (addr % 2 == 0) : 1'b1;
        legal   = size_ok && align;
        e_req   = v && legal && (q.size() < OUT);
        e_rdy   = legal ? (e_req && gnt) : v;
        e_exc   = v && !legal;
        code    = !size_ok ? (we ? 6'd7 : 6'd5) : (we ? 6'd6 : 6'd4);
        chk("obi_req", ifc.obi_req_o, e_req);
        chk("mem_ready", ifc.mem_ready_o, e_rdy);
        chk("exc", ifc.mem_resp_exc_o, e_exc);
        if (e_exc) chk("exccode", ifc.mem_resp_exccode_o, code);
        if (e_req) begin
            chk("obi_addr", ifc.obi_addr_o, addr);
            chk("obi_we", ifc.obi_we_o, we);
            chk("obi_wdata", ifc.obi_wdata_o, wd);
        end
        @(posedge clk);
        had  = q.size();
        e_rv = rv && (had > 0);
        if (e_rv) begin
            e_id = q[0].id;
            e_rd = q[0].we ? 32'h0 : rd;
            e_er = er;
            void'(q.pop_front());
        end
        if (rv && had == 0) e_perr = 1'b1;
        if (e_req && gnt) q.push_back('{id: id, we: we});
        #1;
        chk("res_valid", ifc.mem_result_valid_o, e_rv);
        if (e_rv) begin
            chk("res_id", ifc.mem_result_id_o, e_id);
            chk("res_rdata", ifc.mem_result_rdata_o, e_rd);
            chk("res_err", ifc.mem_result_err_o, e_er);
        end
        chk("busy", ifc.busy_o, q.size() != 0);
        chk("protocol_err", ifc.protocol_err_o, e_perr);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, 32'h0, 1'b0, 3'd4, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    task automatic rsp(input logic [31:0] rd, input logic er);
        cyc(1'b0, 4'h0, 32'h0, 1'b0, 3'd4, 32'h0, 1'b0, 1'b1, rd, er);
    endtask

    task automatic do_reset();
        ifc.mem_valid_i  = 1'b0;
        ifc.obi_gnt_i    = 1'b0;
        ifc.obi_rvalid_i = 1'b0;
        rst = 1'b1;
        #1;
        q.delete();
        e_rv = 1'b0;
        e_perr = 1'b0;
        chk("rst_res_valid", ifc.mem_result_valid_o, 1'b0);
        chk("rst_busy", ifc.busy_o, 1'b0);
        chk("rst_perr", ifc.protocol_err_o, 1'b0);
        chk("rst_obi_req", ifc.obi_req_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic [2:0]  sizes [6] = '{3'd1, 3'd2, 3'd4, 3'd4, 3'd3, 3'd0};
        logic [31:0] a;
        ifc.mem_valid_i = 1'b0; ifc.mem_id_i = '0; ifc.mem_addr_i = '0; ifc.mem_we_i = 1'b0;
        ifc.mem_size_i = 3'd4; ifc.mem_be_i = '0; ifc.mem_wdata_i = '0; ifc.mem_last_i = 1'b1;
        ifc.obi_gnt_i = 1'b0; ifc.obi_rvalid_i = 1'b0; ifc.obi_rdata_i = '0; ifc.obi_err_i = 1'b0;
        @(negedge clk);
        do_reset();

        // single word load
        cyc(1'b1, 4'd3, 32'h100, 1'b0, 3'd4, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        idle(1);
        rsp(32'hDEADBEEF, 1'b0);
        chk("load_id", ifc.mem_result_id_o, 32'd3);
        chk("load_rdata", ifc.mem_result_rdata_o, 32'hDEADBEEF);

        // word store
        cyc(1'b1, 4'd5, 32'h204, 1'b1, 3'd4, 32'h12345678, 1'b1, 1'b0, 32'h0, 1'b0);
        rsp(32'hFFFF0000, 1'b0);
        chk("store_rdata", ifc.mem_result_rdata_o, 32'h0);

        // misaligned load, illegal-size store, misaligned half store
        cyc(1'b1, 4'd7, 32'h102, 1'b0, 3'd4, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 4'd8, 32'h100, 1'b1, 3'd3, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 4'd9, 32'h101, 1'b1, 3'd2, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        idle(1);

        // fill FIFO, then id 3 waits for a freed slot
        cyc(1'b1, 4'd1, 32'h10, 1'b0, 3'd4, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 4'd2, 32'h14, 1'b0, 3'd4, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 4'd3, 32'h18, 1'b0, 3'd4, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 4'd3, 32'h18, 1'b0, 3'd4, 32'h0, 1'b1, 1'b1, 32'hA1, 1'b0);
        chk("full_first_id", ifc.mem_result_id_o, 32'd1);
        cyc(1'b1, 4'd3, 32'h18, 1'b0, 3'd4, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        rsp(32'hA2, 1'b0);
        chk("full_second_id", ifc.mem_result_id_o, 32'd2);

        // push and pop together with one outstanding, then a bus error
        cyc(1'b1, 4'd6, 32'h20, 1'b0, 3'd2, 32'h0, 1'b1, 1'b1, 32'hA3, 1'b0);
        chk("pushpop_id", ifc.mem_result_id_o, 32'd3);
        chk("pushpop_busy", ifc.busy_o, 32'd1);
        rsp(32'hA4, 1'b1);
        chk("err_flag", ifc.mem_result_err_o, 32'd1);

        // reset with two outstanding; the late rvalid is stray
        cyc(1'b1, 4'd10, 32'h30, 1'b0, 3'd1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        cyc(1'b1, 4'd11, 32'h31, 1'b0, 3'd1, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();
        rsp(32'h55, 1'b0);
        chk("stray_perr", ifc.protocol_err_o, 32'd1);
        idle(3);
        cyc(1'b1, 4'd12, 32'h40, 1'b0, 3'd4, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        rsp(32'h66, 1'b0);
        chk("perr_sticky", ifc.protocol_err_o, 32'd1);
        do_reset();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            cyc(1'($urandom), 4'($urandom), a, 1'($urandom), sizes[$urandom_range(0, 5)],
                $urandom, 1'($urandom), (q.size() > 0) && ($urandom_range(0, 2) != 0),
                $urandom, ($urandom_range(0, 7) == 0));
        end
        while (q.size() > 0) rsp($urandom, 1'b0);
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
